// File: rtl/br_param.sv
// Clocked register bank: 2 combinational read ports, 1 synchronous write port, self-clearing after reset.
// Latency: reads are combinational; a write is visible the same cycle with BYPASS=1, next cycle otherwise.
// No backpressure: busy is high for DEPTH cycles after reset, and during that time writes are dropped and reads return 0.
module br_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic [DATA_W-1:0] dr1,
  output logic [DATA_W-1:0] dr2,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              byp1;
  logic              byp2;

  assign busy = (state == CLEAR);

  // A write only lands outside the clear phase, and never on a hardwired zero entry.
  assign wr_ok = we && !busy && !(ZERO_REG && (wa == '0));

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next state: leave CLEAR on the edge that clears the last entry.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (&clr_cnt) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Clear pointer walks through every entry once per clear phase.
  always_ff @(posedge clk) begin
    if (reset)      clr_cnt <= '0;
    else if (busy)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Storage: the sequencer owns the write port while busy. Storage is left untouched in the reset cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy)       mem[clr_cnt] <= '0;
      else if (wr_ok) mem[wa]      <= wd;
    end
  end

  assign byp1 = BYPASS && wr_ok && (rr1 == wa);
  assign byp2 = BYPASS && wr_ok && (rr2 == wa);

  assign dr1 = (busy || (ZERO_REG && (rr1 == '0))) ? '0 : (byp1 ? wd : mem[rr1]);
  assign dr2 = (busy || (ZERO_REG && (rr2 == '0))) ? '0 : (byp2 ? wd : mem[rr2]);

endmodule

// File: tb/tb_br_param.sv
// Testbench for br_param: four instances cover every ZERO_REG/BYPASS combination, all driven by the same stimulus.
// Each instance is compared every cycle against an array model of the register file with a countdown for the busy phase.
// Directed steps come first, followed by a random read/write stream.
module tb_br_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] rr1;
  logic [AW-1:0] rr2;
  logic [DW-1:0] dr1_o [4];
  logic [DW-1:0] dr2_o [4];
  logic          busy_o [4];

  int checks   = 0;
  int failures = 0;

  // Model: per-config register contents plus the number of busy cycles still to go.
  logic [DW-1:0] mm [4][DEPTH];
  int            busy_left = 0;
  logic          last_busy;
  int            busy_cycles;

  always #5 clk = ~clk;

  // Configurations: 0 = ZR1/BP1, 1 = ZR1/BP0, 2 = ZR0/BP1, 3 = ZR0/BP0
  br_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .rr1(rr1), .rr2(rr2),
    .dr1(dr1_o[0]), .dr2(dr2_o[0]), .busy(busy_o[0]));
  br_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .rr1(rr1), .rr2(rr2),
    .dr1(dr1_o[1]), .dr2(dr2_o[1]), .busy(busy_o[1]));
  br_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b1)) u2 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .rr1(rr1), .rr2(rr2),
    .dr1(dr1_o[2]), .dr2(dr2_o[2]), .busy(busy_o[2]));
  br_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u3 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .rr1(rr1), .rr2(rr2),
    .dr1(dr1_o[3]), .dr2(dr2_o[3]), .busy(busy_o[3]));

  function automatic bit zr(input int c);
    return (c < 2);
  endfunction

  function automatic bit bp(input int c);
    return (c % 2) == 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int c, input logic [AW-1:0] ra);
    if (busy_left > 0)                                        return '0;
    if (zr(c) && ra == 0)                                     return '0;
    if (bp(c) && we && ra == wa && !(zr(c) && wa == 0))       return wd;
    return mm[c][ra];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check every instance against the model while the inputs are stable (falling edge).
  task automatic sample();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("c%0d_busy", c), DW'(busy_o[c]), DW'(busy_left > 0));
      chk($sformatf("c%0d_dr1", c), dr1_o[c], exp_rd(c, rr1));
      chk($sformatf("c%0d_dr2", c), dr2_o[c], exp_rd(c, rr2));
    end
    last_busy = busy_o[0];
  endtask

  // Advance past the rising edge and apply the same edge to the model.
  task automatic commit();
    @(posedge clk);
    if (reset) begin
      busy_left = DEPTH;
      for (int c = 0; c < 4; c++)
        for (int a = 0; a < DEPTH; a++) mm[c][a] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (we) begin
      for (int c = 0; c < 4; c++)
        if (!(zr(c) && wa == 0)) mm[c][wa] = wd;
    end
    #1;
  endtask

  task automatic rand_reads();
    rr1 = AW'($urandom_range(0, DEPTH - 1));
    rr2 = AW'($urandom_range(0, DEPTH - 1));
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; rr1 = '0; rr2 = '0;
    // Initial reset edge; outputs are undefined before it, so nothing is checked here.
    commit();
    reset = 1'b0;

    // T1: count busy cycles after a one-cycle reset; reads must return 0 throughout.
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      rand_reads();
      sample();
      if (!last_busy) break;
      busy_cycles++;
      commit();
    end
    chk("t1_busy_len", DW'(busy_cycles), DW'(32));
    chk("t1_ready_rd", dr1_o[0], '0);
    commit();

    // T2: write 5 with rr2=5 in the same cycle, then read it back on the next cycle.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; rr1 = 5'd3; rr2 = 5'd5;
    sample();
    chk("t2_byp_c0", dr2_o[0], 32'hDEADBEEF);
    chk("t2_old_c1", dr2_o[1], 32'h0);
    chk("t2_byp_c2", dr2_o[2], 32'hDEADBEEF);
    chk("t2_old_c3", dr2_o[3], 32'h0);
    commit();
    we = 1'b0; rr1 = 5'd5; rr2 = 5'd5;
    sample();
    for (int c = 0; c < 4; c++) chk($sformatf("t2_rd_c%0d", c), dr1_o[c], 32'hDEADBEEF);
    commit();

    // T3: write to entry 0.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rr1 = 5'd0; rr2 = 5'd0;
    sample();
    chk("t3_wc_c0", dr1_o[0], 32'h0);
    chk("t3_wc_c1", dr1_o[1], 32'h0);
    chk("t3_wc_c2", dr1_o[2], 32'hFFFFFFFF);
    chk("t3_wc_c3", dr1_o[3], 32'h0);
    commit();
    we = 1'b0;
    sample();
    chk("t3_af_c0", dr1_o[0], 32'h0);
    chk("t3_af_c1", dr1_o[1], 32'h0);
    chk("t3_af_c2", dr1_o[2], 32'hFFFFFFFF);
    chk("t3_af_c3", dr1_o[3], 32'hFFFFFFFF);
    commit();

    // T4: write reg 31, reset, then re-assert reset at clear cycle 10; T5: writes during busy.
    we = 1'b1; wa = 5'd31; wd = 32'h12345678;
    sample();
    commit();
    we = 1'b0; rr1 = 5'd31;
    sample();
    chk("t4_wr31", dr1_o[3], 32'h12345678);
    commit();
    reset = 1'b1;
    sample();
    commit();
    reset = 1'b0;
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
    for (int i = 0; i < 10; i++) begin
      rand_reads();
      sample();
      commit();
    end
    reset = 1'b1;
    sample();
    commit();
    reset = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      we = (i < 20);
      rand_reads();
      sample();
      if (!last_busy) break;
      busy_cycles++;
      commit();
    end
    chk("t4_busy_len", DW'(busy_cycles), DW'(32));
    commit();
    we = 1'b0; rr1 = 5'd31; rr2 = 5'd7;
    sample();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t4_r31_c%0d", c), dr1_o[c], 32'h0);
      chk($sformatf("t5_r7_c%0d", c), dr2_o[c], 32'h0);
    end
    commit();

    // T6: random stream with overlapping read addresses and frequent read-of-write-address.
    for (int i = 0; i < 1000; i++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      rr1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      rr2 = ($urandom_range(0, 2) == 0) ? rr1 : AW'($urandom_range(0, DEPTH - 1));
      sample();
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
